capt_reader: RTL and testbench

CAPT_READER -- requirements
Module: capt_reader

---
 rtl/capt_pkg.sv | 23 ++
 rtl/capt_fifo.sv | 54 +++++
 rtl/capt_reader.sv | 133 +++++++++++++
 tb/tb_capt_reader.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capt_pkg.sv
// Shared definitions for the capture-buffer reader: FSM states, word/byte
// geometry and a small unsigned minimum helper.
`timescale 1ns/1ps
package capt_pkg;

    localparam int WORD_W     = 32;
    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = 2;
    localparam int BCNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_REQ,
        ST_DATA
    } state_t;

    function automatic logic [WORD_W-1:0] min_u32(input logic [WORD_W-1:0] a,
                                                   input logic [WORD_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/capt_fifo.sv
// Synchronous show-ahead FIFO: rd_data presents the head word whenever
// empty is low, and a pop simply advances to the next entry.
`timescale 1ns/1ps
module capt_fifo
    import capt_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [31:0]              wr_data,
    input  logic                     rd_en,
    output logic [31:0]              rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   usedw
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic              wr_ok;
    logic              rd_ok;

    assign empty   = (usedw == '0);
    assign wr_ok   = wr_en && (usedw != FULL);
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_idx];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_idx <= '0;
            rd_idx <= '0;
            usedw  <= '0;
        end else begin
            if (wr_ok) wr_idx <= wr_idx + 1'b1;
            if (rd_ok) rd_idx <= rd_idx + 1'b1;
            if (wr_ok && !rd_ok)      usedw <= usedw + 1'b1;
            else if (!wr_ok && rd_ok) usedw <= usedw - 1'b1;
        end
    end

    // NOTE: the storage array carries no reset; emptiness is defined by the
    // pointers and usedw, so clearing words would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_idx] <= wr_data;
    end

endmodule

// File: rtl/capt_reader.sv
// Drains a circular capture buffer over Avalon-MM read bursts into a
// show-ahead FIFO that feeds a valid/ready output stream.
`timescale 1ns/1ps
module capt_reader
    import capt_pkg::*;
#(
    parameter int BURST_MAX  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] capt_buf_start,
    input  logic [31:0] capt_buf_size,
    input  logic [31:0] last_write_addr,
    output logic [31:0] address,
    output logic        read,
    output logic [15:0] burstcount,
    input  logic [31:0] readdata,
    input  logic        readdatavalid,
    input  logic        waitrequest,
    output logic [31:0] st_data,
    output logic        st_valid,
    input  logic        st_ready,
    output logic        busy,
    output logic [31:0] rd_ptr
);

    localparam int UW = $clog2(FIFO_DEPTH);

    state_t              state;
    state_t              next_state;
    logic [BCNT_W-1:0]   inflight;
    logic [UW:0]         usedw;
    logic                fifo_empty;
    logic                fifo_wr;
    logic                fifo_rd;
    logic [WORD_W-1:0]   buf_end;
    logic [WORD_W-1:0]   avail_bytes;
    logic [WORD_W-1:0]   avail_words;
    logic [WORD_W-1:0]   to_end_words;
    logic [WORD_W-1:0]   occupied;
    logic [WORD_W-1:0]   free_words;
    logic [WORD_W-1:0]   len;
    logic [WORD_W-1:0]   next_ptr;

    capt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (readdata),
        .rd_en   (fifo_rd),
        .rd_data (st_data),
        .empty   (fifo_empty),
        .usedw   (usedw)
    );

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        st_valid   = !fifo_empty;
        fifo_rd    = st_valid && st_ready;
        fifo_wr    = (state == ST_DATA) && readdatavalid;
        busy       = (state != ST_IDLE);

        // Both pointers live inside the buffer, so one conditional add of the
        // size is the full modulo.
        buf_end     = capt_buf_start + capt_buf_size;
        avail_bytes = last_write_addr - rd_ptr;
        if (last_write_addr < rd_ptr) avail_bytes = avail_bytes + capt_buf_size;
        avail_words  = avail_bytes >> WORD_SHIFT;
        to_end_words = (buf_end - rd_ptr) >> WORD_SHIFT;

        // One slot stays spare so a full burst can never meet a full FIFO.
        occupied   = 32'(usedw) + 32'(inflight) + 32'd1;
        free_words = (occupied < 32'(FIFO_DEPTH)) ? 32'(FIFO_DEPTH) - occupied : '0;
        len        = min_u32(min_u32(32'(BURST_MAX), avail_words),
                             min_u32(to_end_words, free_words));

        next_ptr = rd_ptr + (32'(burstcount) << WORD_SHIFT);
        if (next_ptr == buf_end) next_ptr = capt_buf_start;

        unique case (state)
            ST_IDLE: if (start) next_state = ST_CALC;
            ST_CALC: begin
                if (stop)            next_state = ST_IDLE;
                else if (len != '0)  next_state = ST_REQ;
            end
            ST_REQ:  if (!waitrequest) next_state = ST_DATA;
            ST_DATA: if (readdatavalid && inflight == 16'd1) next_state = ST_CALC;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            read       <= 1'b0;
            address    <= '0;
            burstcount <= '0;
            rd_ptr     <= '0;
            inflight   <= '0;
        end else begin
            state <= next_state;
            unique case (state)
                ST_IDLE: if (start) rd_ptr <= capt_buf_start;
                ST_CALC: begin
                    if (next_state == ST_REQ) begin
                        read       <= 1'b1;
                        address    <= rd_ptr;
                        burstcount <= BCNT_W'(len);
                    end
                end
                ST_REQ: begin
                    if (!waitrequest) begin
                        read     <= 1'b0;
                        inflight <= burstcount;
                    end
                end
                ST_DATA: begin
                    if (readdatavalid) begin
                        inflight <= inflight - 16'd1;
                        if (inflight == 16'd1) rd_ptr <= next_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_capt_reader.sv
// Directed bench for capt_reader: an Avalon slave model serves words derived
// from their address, and a queue holds the stream the buffer contents imply.
`timescale 1ns/1ps
module tb_capt_reader;

    localparam int BURST_MAX  = 16;
    localparam int FIFO_DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [31:0] capt_buf_start;
    logic [31:0] capt_buf_size;
    logic [31:0] last_write_addr;
    logic [31:0] address;
    logic        read;
    logic [15:0] burstcount;
    logic [31:0] readdata = '0;
    logic        readdatavalid = 1'b0;
    logic        waitrequest = 1'b0;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic        busy;
    logic [31:0] rd_ptr;

    capt_reader #(.BURST_MAX(BURST_MAX), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .capt_buf_start  (capt_buf_start),
        .capt_buf_size   (capt_buf_size),
        .last_write_addr (last_write_addr),
        .address         (address),
        .read            (read),
        .burstcount      (burstcount),
        .readdata        (readdata),
        .readdatavalid   (readdatavalid),
        .waitrequest     (waitrequest),
        .st_data         (st_data),
        .st_valid        (st_valid),
        .st_ready        (st_ready),
        .busy            (busy),
        .rd_ptr          (rd_ptr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory contents are a pure function of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Model: the stream must carry the words from one pointer up to the writer
    // address, walking the circular buffer.
    logic [31:0] exp_q[$];
    logic [31:0] buf_lo = '0;
    logic [31:0] buf_sz = 32'd4;

    task automatic push_range(input logic [31:0] from, input logic [31:0] to);
        logic [31:0] a;
        a = from;
        for (int guard = 0; guard < 4096 && a != to; guard++) begin
            exp_q.push_back(mem_word(a));
            a += 4;
            if (a == buf_lo + buf_sz) a = buf_lo;
        end
    endtask

    // Slave and command-log state.
    int          stall_cfg   = 0;
    int          stall_left  = 0;
    int          stall_seen  = 0;
    bit          cmd_active  = 1'b0;
    bit          gap_cfg     = 1'b0;
    bit          gap_ph      = 1'b0;
    int          pend        = 0;
    int          beats_rx    = 0;
    int          popped      = 0;
    logic [31:0] beat_addr   = '0;
    logic [31:0] held_addr   = '0;
    logic [15:0] held_bc     = '0;
    logic [31:0] mdl_ptr     = '0;
    logic [31:0] cmd_addr_q[$];
    int          cmd_bc_q[$];

    always @(negedge clk) begin : slave
        readdatavalid = 1'b0;
        if (pend > 0) begin
            gap_ph = ~gap_ph;
            if (!gap_cfg || gap_ph) begin
                readdatavalid = 1'b1;
                readdata      = mem_word(beat_addr);
                beat_addr    += 4;
                pend--;
                beats_rx++;
            end
        end
        waitrequest = 1'b0;
        if (read === 1'b1) begin
            if (!cmd_active) begin
                cmd_active = 1'b1;
                stall_left = stall_cfg;
                held_addr  = address;
                held_bc    = burstcount;
            end else begin
                check("req_addr_stable", address, held_addr);
                check("req_bc_stable", 32'(burstcount), 32'(held_bc));
            end
            if (stall_left > 0) begin
                waitrequest = 1'b1;
                stall_left--;
                stall_seen++;
            end else begin
                cmd_active = 1'b0;
                check("one_outstanding", pend, 0);
                check("cmd_addr", address, mdl_ptr);
                check("cmd_len_range", 32'(burstcount >= 1 && burstcount <= BURST_MAX), 1);
                check("cmd_no_straddle", 32'(address + 4 * burstcount <= buf_lo + buf_sz), 1);
                check("cmd_fits_fifo", 32'(beats_rx - popped + int'(burstcount) <= FIFO_DEPTH - 1), 1);
                cmd_addr_q.push_back(address);
                cmd_bc_q.push_back(int'(burstcount));
                pend      = int'(burstcount);
                beat_addr = address;
                gap_ph    = 1'b0;
                mdl_ptr   = address + 4 * burstcount;
                if (mdl_ptr == buf_lo + buf_sz) mdl_ptr = buf_lo;
            end
        end
    end

    always @(negedge clk) begin : compare
        if (reset === 1'b1 && st_valid === 1'b1 && st_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stream_extra: got 0x%08h, expected no word", st_data);
            end else begin
                check("stream_data", st_data, exp_q.pop_front());
            end
            popped++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic set_buf(input logic [31:0] lo, input logic [31:0] sz);
        buf_lo         = lo;
        buf_sz         = sz;
        capt_buf_start = lo;
        capt_buf_size  = sz;
    endtask

    task automatic drain(input string name, input int budget);
        for (int n = 0; n < budget && exp_q.size() != 0; n++) tick(1);
        check(name, exp_q.size(), 0);
        tick(4);
    endtask

    task automatic clear_log();
        cmd_addr_q.delete();
        cmd_bc_q.delete();
    endtask

    task automatic wait_cmds(input string name, input int count, input int budget);
        for (int n = 0; n < budget && cmd_addr_q.size() < count; n++) tick(1);
        check(name, cmd_addr_q.size(), count);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int words;
        int pend_at_reset;
        reset           = 1'b0;
        start           = 1'b0;
        stop            = 1'b0;
        st_ready        = 1'b0;
        capt_buf_start  = '0;
        capt_buf_size   = 32'd4;
        last_write_addr = '0;
        tick(3);

        // Reset values
        check("rst_read", 32'(read), 0);
        check("rst_address", address, 0);
        check("rst_burstcount", 32'(burstcount), 0);
        check("rst_rd_ptr", rd_ptr, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_st_valid", 32'(st_valid), 0);
        reset = 1'b1;
        tick(2);

        // Base case: 16 words in a single burst
        set_buf(32'h1000, 32'h100);
        last_write_addr = 32'h1040;
        st_ready = 1'b1;
        mdl_ptr  = 32'h1000;
        clear_log();
        push_range(32'h1000, 32'h1040);
        check("base_model_words", exp_q.size(), 16);
        pulse_start();
        drain("base_drain", 500);
        check("base_ncmd", cmd_addr_q.size(), 1);
        check("base_cmd_addr", cmd_addr_q[0], 32'h1000);
        check("base_cmd_bc", cmd_bc_q[0], 16);
        check("base_rd_ptr", rd_ptr, 32'h1040);
        check("base_busy_in_calc", 32'(busy), 1);
        check("base_read_idle", 32'(read), 0);

        // Move the reader to 0x10F0, then wrap around the buffer end
        last_write_addr = 32'h10F0;
        push_range(32'h1040, 32'h10F0);
        drain("prewrap_drain", 500);
        check("prewrap_rd_ptr", rd_ptr, 32'h10F0);
        clear_log();
        last_write_addr = 32'h1020;
        push_range(32'h10F0, 32'h1020);
        check("wrap_model_words", exp_q.size(), 12);
        drain("wrap_drain", 500);
        check("wrap_ncmd", cmd_addr_q.size(), 2);
        check("wrap_cmd0_addr", cmd_addr_q[0], 32'h10F0);
        check("wrap_cmd0_bc", cmd_bc_q[0], 4);
        check("wrap_cmd1_addr", cmd_addr_q[1], 32'h1000);
        check("wrap_cmd1_bc", cmd_bc_q[1], 8);
        check("wrap_rd_ptr", rd_ptr, 32'h1020);

        // Idle via stop, then backpressure with 200 words available
        stop = 1'b1;
        tick(3);
        check("stop_idle_busy", 32'(busy), 0);
        stop     = 1'b0;
        st_ready = 1'b0;
        set_buf(32'h2000, 32'h400);
        last_write_addr = 32'h2320;
        mdl_ptr = 32'h2000;
        clear_log();
        push_range(32'h2000, 32'h2320);
        check("bp_model_words", exp_q.size(), 200);
        pulse_start();
        tick(400);
        words = 0;
        foreach (cmd_bc_q[i]) words += cmd_bc_q[i];
        check("bp_words_capped", words, 63);
        check("bp_read_low", 32'(read), 0);
        check("bp_st_valid", 32'(st_valid), 1);
        check("bp_head_word", st_data, 32'hC0DE_2000);
        st_ready = 1'b1;
        drain("bp_drain", 1500);
        check("bp_rd_ptr", rd_ptr, 32'h2320);

        // Waitrequest held for 5 cycles
        stall_cfg  = 5;
        stall_seen = 0;
        clear_log();
        last_write_addr = 32'h2360;
        push_range(32'h2320, 32'h2360);
        drain("wait_drain", 500);
        check("wait_stall_cycles", stall_seen, 5);
        check("wait_ncmd", cmd_addr_q.size(), 1);
        check("wait_cmd_addr", cmd_addr_q[0], 32'h2320);
        check("wait_cmd_bc", cmd_bc_q[0], 16);
        stall_cfg = 0;

        // Stop mid-DATA: the burst completes, the next one never starts
        gap_cfg = 1'b1;
        clear_log();
        last_write_addr = 32'h23E0;
        push_range(32'h2360, 32'h23A0);
        wait_cmds("stop_cmd_seen", 1, 200);
        tick(4);
        stop = 1'b1;
        for (int n = 0; n < 200 && busy !== 1'b0; n++) tick(1);
        check("stop_busy", 32'(busy), 0);
        drain("stop_drain", 200);
        tick(10);
        check("stop_ncmd", cmd_addr_q.size(), 1);
        check("stop_rd_ptr", rd_ptr, 32'h23A0);
        check("stop_read", 32'(read), 0);
        check("stop_still_idle", 32'(busy), 0);

        // Reset in the middle of a burst, with stray beats afterwards
        stop     = 1'b0;
        st_ready = 1'b0;
        mdl_ptr  = 32'h2000;
        clear_log();
        pulse_start();
        wait_cmds("rst_cmd_seen", 1, 200);
        tick(6);
        reset = 1'b0;
        pend_at_reset = pend;
        tick(2);
        check("midrst_read", 32'(read), 0);
        check("midrst_address", address, 0);
        check("midrst_burstcount", 32'(burstcount), 0);
        check("midrst_rd_ptr", rd_ptr, 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_st_valid", 32'(st_valid), 0);
        reset = 1'b1;
        check("stray_beats_pending", 32'(pend_at_reset > 0), 1);
        for (int n = 0; n < 100 && pend > 0; n++) begin
            tick(1);
            check("stray_no_valid", 32'(st_valid), 0);
        end
        tick(4);
        check("post_rst_st_valid", 32'(st_valid), 0);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_read", 32'(read), 0);
        check("post_rst_rd_ptr", rd_ptr, 0);
        check("post_rst_no_cmd", cmd_addr_q.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
